// File: rtl/dt_param_engine.sv
// Two-pass distance-transform engine.
// A forward raster pass writes provisional distances. A reverse raster pass
// reads them back and tightens them. Row neighbours come from a one-row line
// buffer; in-row neighbours come from two registers. Each pass fetches every
// sti word exactly once.
module dt_param_engine #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int WORD_W = 16,
  parameter int DIST_W = 8,
  parameter int STI_AW = $clog2(IMG_W*IMG_H/WORD_W),
  parameter int RES_AW = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              sti_rd,
  output logic [STI_AW-1:0] sti_addr,
  input  logic [WORD_W-1:0] sti_di,
  output logic              res_rd,
  output logic              res_wr,
  output logic [RES_AW-1:0] res_addr,
  output logic [DIST_W-1:0] res_do,
  input  logic [DIST_W-1:0] res_di
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NWORD = NPIX / WORD_W;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int KW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [RES_AW-1:0] LAST_PIX  = RES_AW'(NPIX - 1);
  localparam logic [STI_AW-1:0] LAST_WORD = STI_AW'(NWORD - 1);
  localparam logic [CW-1:0]     LAST_COL  = CW'(IMG_W - 1);
  localparam logic [KW-1:0]     LAST_K    = KW'(WORD_W - 1);
  localparam logic [DIST_W-1:0] DMAX      = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_F_FETCH,
    S_F_LOAD,
    S_F_PIX,
    S_B_FETCH,
    S_B_LOAD,
    S_B_PIX,
    S_B_RMW,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [CW-1:0]       col_q, col_d;
  logic [KW-1:0]       k_q, k_d;
  logic [STI_AW-1:0]   wa_q, wa_d;
  logic [RES_AW-1:0]   pa_q, pa_d;
  logic [WORD_W-1:0]   word_q, word_d;
  // a_q: in-row neighbour (W in forward pass, E in backward pass)
  // d_q: diagonal neighbour captured from the line buffer before it is overwritten
  logic [DIST_W-1:0]   a_q, a_d;
  logic [DIST_W-1:0]   d_q, d_d;
  logic [DIST_W-1:0]   lb_q [IMG_W];

  logic                lb_we, lb_clr;
  logic [DIST_W-1:0]   lb_wdata;
  logic                adv;
  logic [DIST_W-1:0]   adv_val;

  logic                fwd, pix, edge_near, edge_far;
  logic [CW-1:0]       oth_idx;
  logic [DIST_W-1:0]   n0, n1, n2, n3, mn;
  logic [DIST_W:0]     sum_w;
  logic [DIST_W-1:0]   cand, fwd_val, rmw_val;

  function automatic logic [DIST_W-1:0] dmin(input logic [DIST_W-1:0] x,
                                             input logic [DIST_W-1:0] y);
    return (x < y) ? x : y;
  endfunction

  // Neighbour selection, minimum and saturating increment for the current pixel
  always_comb begin
    fwd       = (state_q inside {S_F_FETCH, S_F_LOAD, S_F_PIX});
    pix       = fwd ? word_q[WORD_W-1] : word_q[0];
    edge_near = fwd ? (col_q == '0) : (col_q == LAST_COL);
    edge_far  = fwd ? (col_q == LAST_COL) : (col_q == '0);
    oth_idx   = col_q;
    if (!edge_far) begin
      oth_idx = fwd ? (col_q + 1'b1) : (col_q - 1'b1);
    end
    n0 = edge_near ? '0 : a_q;
    n1 = edge_near ? '0 : d_q;
    n2 = lb_q[col_q];
    n3 = edge_far ? '0 : lb_q[oth_idx];
    mn = mode_q ? dmin(n0, n2) : dmin(dmin(n0, n1), dmin(n2, n3));
    sum_w   = {1'b0, mn} + 1'b1;
    cand    = sum_w[DIST_W] ? DMAX : sum_w[DIST_W-1:0];
    fwd_val = pix ? cand : '0;
    rmw_val = dmin(res_di, cand);
  end

  // Next-state, bus outputs and pixel-advance bookkeeping
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    col_d    = col_q;
    k_d      = k_q;
    wa_d     = wa_q;
    pa_d     = pa_q;
    word_d   = word_q;
    a_d      = a_q;
    d_d      = d_q;
    lb_we    = 1'b0;
    lb_clr   = 1'b0;
    lb_wdata = '0;
    adv      = 1'b0;
    adv_val  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    sti_rd   = 1'b0;
    sti_addr = '0;
    res_rd   = 1'b0;
    res_wr   = 1'b0;
    res_addr = '0;
    res_do   = '0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          mode_d  = mode;
          wa_d    = '0;
          pa_d    = '0;
          col_d   = '0;
          lb_clr  = 1'b1;
          state_d = S_F_FETCH;
        end
      end
      S_F_FETCH: begin
        busy     = 1'b1;
        sti_rd   = 1'b1;
        sti_addr = wa_q;
        state_d  = S_F_LOAD;
      end
      S_F_LOAD: begin
        busy    = 1'b1;
        word_d  = sti_di;
        k_d     = '0;
        state_d = S_F_PIX;
      end
      S_F_PIX: begin
        busy     = 1'b1;
        res_wr   = 1'b1;
        res_addr = pa_q;
        res_do   = fwd_val;
        adv      = 1'b1;
        adv_val  = fwd_val;
      end
      S_B_FETCH: begin
        busy     = 1'b1;
        sti_rd   = 1'b1;
        sti_addr = wa_q;
        state_d  = S_B_LOAD;
      end
      S_B_LOAD: begin
        busy    = 1'b1;
        word_d  = sti_di;
        k_d     = '0;
        state_d = S_B_PIX;
      end
      S_B_PIX: begin
        busy = 1'b1;
        if (pix) begin
          res_rd   = 1'b1;
          res_addr = pa_q;
          state_d  = S_B_RMW;
        end else begin
          adv     = 1'b1;
          adv_val = '0;
        end
      end
      S_B_RMW: begin
        busy     = 1'b1;
        res_addr = pa_q;
        if (rmw_val != res_di) begin
          res_wr = 1'b1;
          res_do = rmw_val;
        end
        adv     = 1'b1;
        adv_val = rmw_val;
      end
      default: state_d = S_IDLE;
    endcase

    // The old line-buffer entry at col_q becomes the next pixel's diagonal
    // neighbour; it is captured before being replaced by this pixel's value.
    if (adv) begin
      lb_we    = 1'b1;
      lb_wdata = adv_val;
      d_d      = lb_q[col_q];
      a_d      = adv_val;
      k_d      = k_q + 1'b1;
      if (fwd) begin
        word_d = word_q << 1;
        if (pa_q == LAST_PIX) begin
          pa_d    = LAST_PIX;
          wa_d    = LAST_WORD;
          col_d   = LAST_COL;
          lb_clr  = 1'b1;
          state_d = S_B_FETCH;
        end else begin
          pa_d  = pa_q + 1'b1;
          col_d = (col_q == LAST_COL) ? '0 : (col_q + 1'b1);
          if (k_q == LAST_K) begin
            wa_d    = wa_q + 1'b1;
            state_d = S_F_FETCH;
          end else begin
            state_d = S_F_PIX;
          end
        end
      end else begin
        word_d = word_q >> 1;
        if (pa_q == '0) begin
          state_d = S_DONE;
        end else begin
          pa_d  = pa_q - 1'b1;
          col_d = (col_q == '0) ? LAST_COL : (col_q - 1'b1);
          if (k_q == LAST_K) begin
            wa_d    = wa_q - 1'b1;
            state_d = S_B_FETCH;
          end else begin
            state_d = S_B_PIX;
          end
        end
      end
    end
  end

  // State, counters, pixel word and line buffer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      col_q   <= '0;
      k_q     <= '0;
      wa_q    <= '0;
      pa_q    <= '0;
      word_q  <= '0;
      a_q     <= '0;
      d_q     <= '0;
      for (int unsigned i = 0; i < IMG_W; i++) begin
        lb_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      col_q   <= col_d;
      k_q     <= k_d;
      wa_q    <= wa_d;
      pa_q    <= pa_d;
      word_q  <= word_d;
      a_q     <= a_d;
      d_q     <= d_d;
      if (lb_clr) begin
        for (int unsigned i = 0; i < IMG_W; i++) begin
          lb_q[i] <= '0;
        end
      end else if (lb_we) begin
        lb_q[col_q] <= lb_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dt_param_engine.sv
// Directed bench for dt_param_engine with three configurations:
//   A: 32x32, 16-pixel words, 8-bit distances
//   B: 32x32, 16-pixel words, 3-bit distances (saturation)
//   C: 16x8, 8-pixel words, 8-bit distances (word stepping within a row)
`timescale 1ns/1ps
module tb_dt_param_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  int checks;
  int errors;

  // ---------------- DUT A ----------------
  logic        start_a = 1'b0, mode_a = 1'b0;
  logic        busy_a, done_a, sti_rd_a, res_rd_a, res_wr_a;
  logic [5:0]  sti_addr_a;
  logic [15:0] sti_di_a;
  logic [9:0]  res_addr_a;
  logic [7:0]  res_do_a, res_di_a;
  logic [15:0] rom_a [64];
  logic [7:0]  ram_a [1024];
  logic        clr_a = 1'b0;
  int          fetch_a, viol_a;

  dt_param_engine #(.IMG_W(32), .IMG_H(32), .WORD_W(16), .DIST_W(8)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode_a),
    .busy(busy_a), .done(done_a),
    .sti_rd(sti_rd_a), .sti_addr(sti_addr_a), .sti_di(sti_di_a),
    .res_rd(res_rd_a), .res_wr(res_wr_a), .res_addr(res_addr_a),
    .res_do(res_do_a), .res_di(res_di_a)
  );

  // ---------------- DUT B ----------------
  logic        start_b = 1'b0, mode_b = 1'b0;
  logic        busy_b, done_b, sti_rd_b, res_rd_b, res_wr_b;
  logic [5:0]  sti_addr_b;
  logic [15:0] sti_di_b;
  logic [9:0]  res_addr_b;
  logic [2:0]  res_do_b, res_di_b;
  logic [15:0] rom_b [64];
  logic [2:0]  ram_b [1024];
  logic        clr_b = 1'b0;
  int          fetch_b, viol_b;

  dt_param_engine #(.IMG_W(32), .IMG_H(32), .WORD_W(16), .DIST_W(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode_b),
    .busy(busy_b), .done(done_b),
    .sti_rd(sti_rd_b), .sti_addr(sti_addr_b), .sti_di(sti_di_b),
    .res_rd(res_rd_b), .res_wr(res_wr_b), .res_addr(res_addr_b),
    .res_do(res_do_b), .res_di(res_di_b)
  );

  // ---------------- DUT C ----------------
  logic        start_c = 1'b0, mode_c = 1'b0;
  logic        busy_c, done_c, sti_rd_c, res_rd_c, res_wr_c;
  logic [3:0]  sti_addr_c;
  logic [7:0]  sti_di_c;
  logic [6:0]  res_addr_c;
  logic [7:0]  res_do_c, res_di_c;
  logic [7:0]  rom_c [16];
  logic [7:0]  ram_c [128];
  logic        clr_c = 1'b0;
  int          fetch_c, viol_c;

  dt_param_engine #(.IMG_W(16), .IMG_H(8), .WORD_W(8), .DIST_W(8)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .mode(mode_c),
    .busy(busy_c), .done(done_c),
    .sti_rd(sti_rd_c), .sti_addr(sti_addr_c), .sti_di(sti_di_c),
    .res_rd(res_rd_c), .res_wr(res_wr_c), .res_addr(res_addr_c),
    .res_do(res_do_c), .res_di(res_di_c)
  );

  // ROM / RAM models with one-cycle read latency
  always @(posedge clk) begin
    if (sti_rd_a) sti_di_a <= rom_a[sti_addr_a];
    if (sti_rd_b) sti_di_b <= rom_b[sti_addr_b];
    if (sti_rd_c) sti_di_c <= rom_c[sti_addr_c];
  end

  always @(posedge clk) begin
    if (clr_a) begin
      for (int i = 0; i < 1024; i++) ram_a[i] <= 8'hAA;
    end else begin
      if (res_rd_a) res_di_a <= ram_a[res_addr_a];
      if (res_wr_a) ram_a[res_addr_a] <= res_do_a;
    end
  end

  always @(posedge clk) begin
    if (clr_b) begin
      for (int i = 0; i < 1024; i++) ram_b[i] <= 3'h5;
    end else begin
      if (res_rd_b) res_di_b <= ram_b[res_addr_b];
      if (res_wr_b) ram_b[res_addr_b] <= res_do_b;
    end
  end

  always @(posedge clk) begin
    if (clr_c) begin
      for (int i = 0; i < 128; i++) ram_c[i] <= 8'hAA;
    end else begin
      if (res_rd_c) res_di_c <= ram_c[res_addr_c];
      if (res_wr_c) ram_c[res_addr_c] <= res_do_c;
    end
  end

  // sti fetch counters
  always @(posedge clk) begin
    if (sti_rd_a) fetch_a <= fetch_a + 1;
    if (sti_rd_b) fetch_b <= fetch_b + 1;
    if (sti_rd_c) fetch_c <= fetch_c + 1;
  end

  // Bus rule monitors: no simultaneous rd/wr, no RAM access while not busy,
  // addresses inside the image
  always @(negedge clk) begin
    if ((res_rd_a && res_wr_a) || ((res_rd_a || res_wr_a) && !busy_a) ||
        (int'(res_addr_a) >= 1024) || (int'(sti_addr_a) >= 64))
      viol_a <= viol_a + 1;
    if ((res_rd_b && res_wr_b) || ((res_rd_b || res_wr_b) && !busy_b) ||
        (int'(res_addr_b) >= 1024) || (int'(sti_addr_b) >= 64))
      viol_b <= viol_b + 1;
    if ((res_rd_c && res_wr_c) || ((res_rd_c || res_wr_c) && !busy_c) ||
        (int'(res_addr_c) >= 128) || (int'(sti_addr_c) >= 16))
      viol_c <= viol_c + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int w);
    return (w == 0) ? done_a : ((w == 1) ? done_b : done_c);
  endfunction

  task automatic pulse_start(input int w, input logic m);
    @(negedge clk);
    case (w)
      0: begin start_a = 1'b1; mode_a = m; end
      1: begin start_b = 1'b1; mode_b = m; end
      default: begin start_c = 1'b1; mode_c = m; end
    endcase
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic wait_done(input int w, input int npix);
    int cyc;
    cyc = 0;
    while (cyc < 6*npix + 200 && !done_of(w)) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_reached", done_of(w), 1);
    chk("latency_bound", (cyc <= 6*npix + 64), 1);
  endtask

  task automatic run(input int w, input logic m, input int npix);
    pulse_start(w, m);
    wait_done(w, npix);
  endtask

  task automatic clear_rams();
    @(negedge clk);
    clr_a = 1'b1; clr_b = 1'b1; clr_c = 1'b1;
    @(negedge clk);
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
  endtask

  task automatic fill_a(input logic v);
    for (int i = 0; i < 64; i++) rom_a[i] = {16{v}};
  endtask

  task automatic px_a(input int r, input int c, input logic v);
    int p;
    p = r*32 + c;
    rom_a[p/16][15 - (p%16)] = v;
  endtask

  task automatic px_c(input int r, input int c, input logic v);
    int p;
    p = r*16 + c;
    rom_c[p/8][7 - (p%8)] = v;
  endtask

  initial begin
    int f0, cnt, sum, cyc;

    fill_a(1'b0);
    for (int i = 0; i < 64; i++) rom_b[i] = '1;
    for (int i = 0; i < 16; i++) rom_c[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outs_a", {busy_a, done_a, sti_rd_a, res_rd_a, res_wr_a}, 0);
    chk("reset_outs_b", {busy_b, done_b, sti_rd_b}, 0);
    chk("reset_outs_c", {busy_c, done_c, sti_rd_c}, 0);
    reset = 1'b0;

    // Empty image, chessboard
    clear_rams();
    run(0, 1'b0, 1024);
    cnt = 0;
    for (int i = 0; i < 1024; i++) if (ram_a[i] != 8'd0) cnt++;
    chk("empty_nonzero", cnt, 0);
    repeat (5) @(negedge clk);
    chk("empty_done_held", {done_a, busy_a}, 2'b10);

    // 3x3 object at rows 10-12, cols 20-22, chessboard
    fill_a(1'b0);
    for (int r = 10; r <= 12; r++)
      for (int c = 20; c <= 22; c++) px_a(r, c, 1'b1);
    clear_rams();
    run(0, 1'b0, 1024);
    chk("sq_center", ram_a[11*32+21], 2);
    chk("sq_corner_tl", ram_a[10*32+20], 1);
    chk("sq_corner_br", ram_a[12*32+22], 1);
    chk("sq_edge_b", ram_a[12*32+21], 1);
    chk("sq_outside", ram_a[13*32+21], 0);
    cnt = 0; sum = 0;
    for (int i = 0; i < 1024; i++) begin
      if (ram_a[i] != 8'd0) cnt++;
      sum += int'(ram_a[i]);
    end
    chk("sq_nonzero", cnt, 9);
    chk("sq_sum", sum, 10);

    // All ones except (12,12); second start during the forward pass is ignored
    fill_a(1'b1);
    px_a(12, 12, 1'b0);
    f0 = fetch_a;
    pulse_start(0, 1'b0);
    repeat (40) @(negedge clk);
    chk("busy_in_fwd", busy_a, 1);
    pulse_start(0, 1'b1);
    wait_done(0, 1024);
    chk("single_run_fetches", fetch_a - f0, 128);
    chk("hole0_14_14", ram_a[14*32+14], 2);
    chk("hole0_15_15", ram_a[15*32+15], 3);
    chk("hole0_0_0", ram_a[0], 1);
    chk("hole0_31_31", ram_a[31*32+31], 1);
    chk("hole0_hole", ram_a[12*32+12], 0);

    // Reset in the middle of the backward pass, then a city-block run
    f0 = fetch_a;
    pulse_start(0, 1'b0);
    cyc = 0;
    while (cyc < 5000 && (fetch_a - f0) < 70) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_bwd", ((fetch_a - f0) >= 70), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_outs", {busy_a, done_a, sti_rd_a, res_rd_a, res_wr_a}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", {busy_a, done_a}, 0);
    run(0, 1'b1, 1024);
    chk("hole1_14_14", ram_a[14*32+14], 4);
    chk("hole1_15_15", ram_a[15*32+15], 6);
    chk("hole1_12_13", ram_a[12*32+13], 1);

    // Saturation with 3-bit distances on an all-ones image
    run(1, 1'b0, 1024);
    chk("sat_15_15", ram_b[15*32+15], 7);
    chk("sat_6_8", ram_b[6*32+8], 7);
    chk("sat_5_20", ram_b[5*32+20], 6);
    chk("sat_0_5", ram_b[0*32+5], 1);

    // 16x8 image, 8-pixel words, 4x4 object across a word boundary, city-block
    for (int r = 2; r <= 5; r++)
      for (int c = 6; c <= 9; c++) px_c(r, c, 1'b1);
    f0 = fetch_c;
    run(2, 1'b1, 128);
    chk("small_fetches", fetch_c - f0, 32);
    chk("small_3_7", ram_c[3*16+7], 2);
    chk("small_3_8", ram_c[3*16+8], 2);
    chk("small_4_8", ram_c[4*16+8], 2);
    chk("small_2_6", ram_c[2*16+6], 1);
    chk("small_5_9", ram_c[5*16+9], 1);
    chk("small_2_7", ram_c[2*16+7], 1);
    chk("small_1_7", ram_c[1*16+7], 0);
    chk("small_3_5", ram_c[3*16+5], 0);
    cnt = 0; sum = 0;
    for (int i = 0; i < 128; i++) begin
      if (ram_c[i] != 8'd0) cnt++;
      sum += int'(ram_c[i]);
    end
    chk("small_nonzero", cnt, 16);
    chk("small_sum", sum, 20);

    // Bus rules over the whole run
    chk("bus_a", viol_a, 0);
    chk("bus_b", viol_b, 0);
    chk("bus_c", viol_c, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
